// File: rtl/graph_mem_server.sv
// Responder for graph read requests: issues BRAM reads, tags them through a
// fixed-latency pipeline and returns in-order responses under credit flow control.
module graph_mem_server #(
  parameter int PROC_BITS  = 4,
  parameter int DATA_SIZE  = 32,
  parameter int DEPTH      = 1024,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     req_valid_in,
  output logic                     req_ready_out,
  input  logic [31:0]              req_addr_in,
  input  logic [PROC_BITS-1:0]     req_src_in,
  output logic [$clog2(DEPTH)-1:0] mem_addr_out,
  output logic                     mem_en_out,
  input  logic [DATA_SIZE-1:0]     mem_data_in,
  output logic                     resp_valid_out,
  input  logic                     resp_ready_in,
  output logic [PROC_BITS-1:0]     resp_dst_out,
  output logic [DATA_SIZE-1:0]     resp_data_out,
  output logic                     resp_err_out,
  output logic                     busy_out
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [31:0]      DEPTH_W  = 32'(DEPTH);

  logic fire, req_err, push, pop;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [RD_LAT-1:0]                 pipe_vld_q, pipe_vld_d;
  logic [RD_LAT-1:0]                 pipe_err_q, pipe_err_d;
  logic [RD_LAT-1:0][PROC_BITS-1:0]  pipe_src_q, pipe_src_d;

  logic [DATA_SIZE-1:0] fifo_data_q [FIFO_DEPTH];
  logic [DATA_SIZE-1:0] fifo_data_d [FIFO_DEPTH];
  logic [PROC_BITS-1:0] fifo_dst_q  [FIFO_DEPTH];
  logic [PROC_BITS-1:0] fifo_dst_d  [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_err_q, fifo_err_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;

  // Credits cover both the read pipeline and the FIFO, so a push always has room.
  assign req_ready_out  = ~rst_in & (cnt_q < CNT_FULL);
  assign req_err        = (req_addr_in >= DEPTH_W);
  assign fire           = req_valid_in & req_ready_out;
  assign mem_en_out     = fire & ~req_err;
  assign mem_addr_out   = fire ? req_addr_in[ADDR_W-1:0] : '0;
  assign busy_out       = ~rst_in & (cnt_q != '0);
  assign resp_valid_out = ~rst_in & (fifo_cnt_q != '0);
  assign pop            = resp_valid_out & resp_ready_in;
  assign push           = pipe_vld_q[RD_LAT-1];

  assign resp_dst_out  = resp_valid_out ? fifo_dst_q[rd_ptr_q]  : '0;
  assign resp_data_out = resp_valid_out ? fifo_data_q[rd_ptr_q] : '0;
  assign resp_err_out  = resp_valid_out & fifo_err_q[rd_ptr_q];

  always_comb begin
    cnt_d = cnt_q;
    if (fire && !pop) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (pop && !fire) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_comb begin
    pipe_vld_d    = pipe_vld_q;
    pipe_err_d    = pipe_err_q;
    pipe_src_d    = pipe_src_q;
    pipe_vld_d[0] = fire;
    pipe_err_d[0] = req_err;
    pipe_src_d[0] = req_src_in;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_err_d[i] = pipe_err_q[i-1];
      pipe_src_d[i] = pipe_src_q[i-1];
    end
  end

  // Out-of-range tags discard whatever the BRAM returns and enqueue zero data.
  always_comb begin
    fifo_data_d = fifo_data_q;
    fifo_dst_d  = fifo_dst_q;
    fifo_err_d  = fifo_err_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fifo_cnt_d  = fifo_cnt_q;
    if (push) begin
      fifo_data_d[wr_ptr_q] = pipe_err_q[RD_LAT-1] ? '0 : mem_data_in;
      fifo_dst_d[wr_ptr_q]  = pipe_src_q[RD_LAT-1];
      fifo_err_d[wr_ptr_q]  = pipe_err_q[RD_LAT-1];
      wr_ptr_d              = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
    end else if (pop && !push) begin
      fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q      <= '0;
      pipe_vld_q <= '0;
      pipe_err_q <= '0;
      pipe_src_q <= '0;
      fifo_err_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      pipe_vld_q <= pipe_vld_d;
      pipe_err_q <= pipe_err_d;
      pipe_src_q <= pipe_src_d;
      fifo_err_q <= fifo_err_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // Payload storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk_in) begin
    fifo_data_q <= fifo_data_d;
    fifo_dst_q  <= fifo_dst_d;
  end

endmodule
